// File: rtl/uart16550_stream_ctrl.sv
// uart16550_stream_ctrl: initialises a 16550 UART, then polls LSR to move bytes between the UART and tx/rx streams.
module uart16550_stream_ctrl #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       init_done,
  output logic [3:0] line_err,
  input  logic       err_clr
);
  typedef enum logic [3:0] {
    W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR, W_IER,
    IDLE, POLL, POLL_WAIT, RX_READ, RX_WAIT, TX_WRITE
  } state_t;
  state_t state, state_n;
  logic       we, re;
  logic [2:0] addr, addr_q;
  logic [7:0] wdata, wdata_q;
  always_comb begin
    state_n = state;
    we      = 1'b0;
    re      = 1'b0;
    addr    = addr_q;
    wdata   = wdata_q;
    case (state)
      W_LCR_DLAB: begin we = 1'b1; addr = 3'd3; wdata = 8'h80;          state_n = W_DLL;  end
      W_DLL:      begin we = 1'b1; addr = 3'd0; wdata = DIVISOR[7:0];   state_n = W_DLM;  end
      W_DLM:      begin we = 1'b1; addr = 3'd1; wdata = DIVISOR[15:8];  state_n = W_LCR;  end
      W_LCR:      begin we = 1'b1; addr = 3'd3; wdata = LCR_VAL;        state_n = W_FCR;  end
      W_FCR:      begin we = 1'b1; addr = 3'd2; wdata = FCR_VAL;        state_n = W_IER;  end
      W_IER:      begin we = 1'b1; addr = 3'd1; wdata = 8'h00;          state_n = IDLE;   end
      IDLE:       state_n = (tx_valid || !rx_valid) ? POLL : IDLE;
      POLL:       begin re = 1'b1; addr = 3'd5; state_n = POLL_WAIT; end
      // RX has priority; an RX read is only issued when the output slot is free
      POLL_WAIT:  state_n = (reg_rdata[0] && !rx_valid) ? RX_READ :
                            (reg_rdata[5] && tx_valid)  ? TX_WRITE : IDLE;
      RX_READ:    begin re = 1'b1; addr = 3'd0; state_n = RX_WAIT; end
      RX_WAIT:    state_n = IDLE;
      TX_WRITE:   begin we = 1'b1; addr = 3'd0; wdata = tx_data; state_n = IDLE; end
      default:    state_n = W_LCR_DLAB;
    endcase
  end
  // Reset masks the strobes immediately so an aborted access never reaches the UART
  assign reg_we    = HRESETn & we;
  assign reg_re    = HRESETn & re;
  assign tx_ready  = HRESETn & we & (state == TX_WRITE);
  assign reg_addr  = HRESETn ? addr : addr_q;
  assign reg_wdata = HRESETn ? wdata : wdata_q;
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= W_LCR_DLAB;
      addr_q    <= 3'd0;
      wdata_q   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      init_done <= 1'b0;
      line_err  <= 4'd0;
    end else begin
      state    <= state_n;
      addr_q   <= addr;
      wdata_q  <= wdata;
      line_err <= (err_clr ? 4'd0 : line_err) | (state == POLL_WAIT ? reg_rdata[4:1] : 4'd0);
      if (state == W_IER) init_done <= 1'b1;
      if (state == RX_WAIT) begin
        rx_valid <= 1'b1;
        rx_data  <= reg_rdata;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
  end
endmodule
